// File: rtl/maze_pkg.sv
// Shared types and constants for the maze navigator.
// Holds the grid size, the planner's "unreachable" distance code, the move
// direction encoding, the run status codes and the navigator state encoding.
package maze_pkg;

    localparam int unsigned GRID_W   = 10;
    localparam int unsigned GRID_H   = 10;
    localparam logic [3:0]  MAX_X    = 4'(GRID_W - 1);
    localparam logic [3:0]  MAX_Y    = 4'(GRID_H - 1);
    localparam logic [6:0]  DIST_INF = 7'h7F;

    typedef enum logic [1:0] {
        DirN = 2'b00,
        DirE = 2'b01,
        DirS = 2'b10,
        DirW = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        StatArrived      = 2'b00,
        StatNopath       = 2'b01,
        StatLimit        = 2'b10,
        StatTimeoutAbort = 2'b11
    } nav_status_t;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StDecide,
        StMove,
        StFinish
    } nav_state_t;

endpackage

// File: rtl/maze_coord_step.sv
// Combinational single-cell step on the 10x10 grid.
// Ports:
//   x, y      current cell
//   dir       direction to step (N = y-1, E = x+1, S = y+1, W = x-1)
//   next_x/y  neighbouring cell in that direction
//   off_grid  the step (or the current cell itself) lies outside 0..9
module maze_coord_step
    import maze_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [1:0] dir,
    output logic [3:0] next_x,
    output logic [3:0] next_y,
    output logic       off_grid
);

    always_comb begin
        next_x   = x;
        next_y   = y;
        off_grid = (x > MAX_X) || (y > MAX_Y);
        unique case (dir_t'(dir))
            DirN: begin
                next_y   = y - 4'd1;
                off_grid = off_grid || (y == 4'd0);
            end
            DirE: begin
                next_x   = x + 4'd1;
                off_grid = off_grid || (x >= MAX_X);
            end
            DirS: begin
                next_y   = y + 4'd1;
                off_grid = off_grid || (y >= MAX_Y);
            end
            DirW: begin
                next_x   = x - 4'd1;
                off_grid = off_grid || (x == 4'd0);
            end
        endcase
    end

endmodule

// File: rtl/maze_nav_controller.sv
// Closed-loop navigator around the BFS wavefront planner.
// Each step: launch the planner, wait for its done pulse, turn the returned
// direction into one move request, and after the motion stage accepts it
// update the position and replan.
// Ports:
//   clk, rstn                       clock, synchronous active-low reset
//   go, abort                       run start pulse, run abort level
//   start_x/y, goal_x/y             run coordinates, sampled on go
//   bfs_start, bfs_goal_x/y         planner launch pulse and latched goal
//   curr_x/y                        robot position (also feeds the planner)
//   bfs_done, bfs_dist_curr,
//   bfs_next_dir, bfs_next_valid    planner results
//   move_valid, move_dir, move_ready  move handshake to the motion stage
//   busy, done, status, step_count  run progress and result
module maze_nav_controller
    import maze_pkg::*;
#(
    parameter int unsigned MAX_STEPS   = 200,
    parameter int unsigned BFS_TIMEOUT = 16383
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       go,
    input  logic       abort,
    input  logic [3:0] start_x,
    input  logic [3:0] start_y,
    input  logic [3:0] goal_x,
    input  logic [3:0] goal_y,
    output logic       bfs_start,
    output logic [3:0] bfs_goal_x,
    output logic [3:0] bfs_goal_y,
    output logic [3:0] curr_x,
    output logic [3:0] curr_y,
    input  logic       bfs_done,
    input  logic [6:0] bfs_dist_curr,
    input  logic [1:0] bfs_next_dir,
    input  logic       bfs_next_valid,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic [7:0] step_count
);

    localparam int unsigned TmoW   = $clog2(BFS_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(BFS_TIMEOUT);

    nav_state_t  state_q, state_d;
    nav_status_t status_q, status_d;
    logic [3:0]  curr_x_q, curr_x_d, curr_y_q, curr_y_d;
    logic [3:0]  goal_x_q, goal_x_d, goal_y_q, goal_y_d;
    logic [7:0]  step_q, step_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [6:0]  plan_dist_q, plan_dist_d;
    logic [1:0]  plan_dir_q, plan_dir_d;
    logic        plan_valid_q, plan_valid_d;
    logic        move_valid_q, move_valid_d;
    logic [1:0]  move_dir_q, move_dir_d;
    logic        bfs_start_q, bfs_start_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  step_x, step_y;
    logic        step_off;
    logic        abort_hit;

    // One stepper serves both the DECIDE guard and the MOVE update; the
    // direction it sees is the registered planner answer in both states.
    maze_coord_step u_step (
        .x        (curr_x_q),
        .y        (curr_y_q),
        .dir      (plan_dir_q),
        .next_x   (step_x),
        .next_y   (step_y),
        .off_grid (step_off)
    );

    assign abort_hit = abort && (state_q != StIdle) && (state_q != StFinish);

    always_comb begin
        state_d      = state_q;
        status_d     = status_q;
        curr_x_d     = curr_x_q;
        curr_y_d     = curr_y_q;
        goal_x_d     = goal_x_q;
        goal_y_d     = goal_y_q;
        step_d       = step_q;
        tmo_d        = tmo_q;
        plan_dist_d  = plan_dist_q;
        plan_dir_d   = plan_dir_q;
        plan_valid_d = plan_valid_q;
        move_valid_d = move_valid_q;
        move_dir_d   = move_dir_q;
        bfs_start_d  = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    curr_x_d = start_x;
                    curr_y_d = start_y;
                    goal_x_d = goal_x;
                    goal_y_d = goal_y;
                    step_d   = 8'd0;
                    busy_d   = 1'b1;
                    if ((start_x > MAX_X) || (start_y > MAX_Y) ||
                        (goal_x > MAX_X) || (goal_y > MAX_Y)) begin
                        status_d = StatNopath;
                        state_d  = StFinish;
                    end else begin
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                if ((curr_x_q == goal_x_q) && (curr_y_q == goal_y_q)) begin
                    status_d = StatArrived;
                    state_d  = StFinish;
                end else if (32'(step_q) == MAX_STEPS) begin
                    status_d = StatLimit;
                    state_d  = StFinish;
                end else begin
                    bfs_start_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                tmo_d = tmo_q + 1'b1;
                // A done on the expiry cycle still counts as done.
                if (bfs_done) begin
                    plan_dist_d  = bfs_dist_curr;
                    plan_dir_d   = bfs_next_dir;
                    plan_valid_d = bfs_next_valid;
                    state_d      = StDecide;
                end else if (tmo_d == TmoMax) begin
                    status_d = StatTimeoutAbort;
                    state_d  = StFinish;
                end
            end
            StDecide: begin
                if ((plan_dist_q == DIST_INF) || !plan_valid_q || step_off) begin
                    status_d = StatNopath;
                    state_d  = StFinish;
                end else begin
                    move_dir_d   = plan_dir_q;
                    move_valid_d = 1'b1;
                    state_d      = StMove;
                end
            end
            StMove: begin
                if (move_valid_q && move_ready) begin
                    move_valid_d = 1'b0;
                    curr_x_d     = step_x;
                    curr_y_d     = step_y;
                    step_d       = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
                    state_d      = StLaunch;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides whatever the active state decided, including a
        // move handshake in the same cycle.
        if (abort_hit) begin
            state_d      = StFinish;
            status_d     = StatTimeoutAbort;
            move_valid_d = 1'b0;
            bfs_start_d  = 1'b0;
            curr_x_d     = curr_x_q;
            curr_y_d     = curr_y_q;
            step_d       = step_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            status_q     <= StatArrived;
            curr_x_q     <= '0;
            curr_y_q     <= '0;
            goal_x_q     <= '0;
            goal_y_q     <= '0;
            step_q       <= '0;
            tmo_q        <= '0;
            plan_dist_q  <= '0;
            plan_dir_q   <= '0;
            plan_valid_q <= 1'b0;
            move_valid_q <= 1'b0;
            move_dir_q   <= '0;
            bfs_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            curr_x_q     <= curr_x_d;
            curr_y_q     <= curr_y_d;
            goal_x_q     <= goal_x_d;
            goal_y_q     <= goal_y_d;
            step_q       <= step_d;
            tmo_q        <= tmo_d;
            plan_dist_q  <= plan_dist_d;
            plan_dir_q   <= plan_dir_d;
            plan_valid_q <= plan_valid_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
            bfs_start_q  <= bfs_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bfs_start  = bfs_start_q;
    assign bfs_goal_x = goal_x_q;
    assign bfs_goal_y = goal_y_q;
    assign curr_x     = curr_x_q;
    assign curr_y     = curr_y_q;
    assign move_valid = move_valid_q;
    assign move_dir   = move_dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_maze_nav_controller.sv
// Randomized bench for maze_nav_controller. The bench plays both the planner
// and the motion stage and keeps its own model of position, step count and
// run outcome, derived from the navigation rules.
module tb_maze_nav_controller;

    localparam int unsigned MAXS = 8;
    localparam int unsigned TMO  = 100;

    localparam int M_GREEDY = 0, M_WANDER = 1, M_NOPATH = 2, M_NOVALID = 3;
    localparam int M_OFFGRID = 4, M_TIMEOUT = 5, M_ABORT = 6, M_ABORT_WAIT = 7;
    localparam int R_HIGH = 0, R_RAND = 1, R_LOW50 = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       go, abort;
    logic [3:0] start_x, start_y, goal_x, goal_y;
    logic       bfs_start;
    logic [3:0] bfs_goal_x, bfs_goal_y, curr_x, curr_y;
    logic       bfs_done;
    logic [6:0] bfs_dist_curr;
    logic [1:0] bfs_next_dir;
    logic       bfs_next_valid;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_ready;
    logic       busy, done;
    logic [1:0] status;
    logic [7:0] step_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    maze_nav_controller #(
        .MAX_STEPS   (MAXS),
        .BFS_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .go             (go),
        .abort          (abort),
        .start_x        (start_x),
        .start_y        (start_y),
        .goal_x         (goal_x),
        .goal_y         (goal_y),
        .bfs_start      (bfs_start),
        .bfs_goal_x     (bfs_goal_x),
        .bfs_goal_y     (bfs_goal_y),
        .curr_x         (curr_x),
        .curr_y         (curr_y),
        .bfs_done       (bfs_done),
        .bfs_dist_curr  (bfs_dist_curr),
        .bfs_next_dir   (bfs_next_dir),
        .bfs_next_valid (bfs_next_valid),
        .move_valid     (move_valid),
        .move_dir       (move_dir),
        .move_ready     (move_ready),
        .busy           (busy),
        .done           (done),
        .status         (status),
        .step_count     (step_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Direction codes: 0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1)
    function automatic int nxt_x(input int x, input int d);
        if (d == 1) return x + 1;
        if (d == 3) return x - 1;
        return x;
    endfunction

    function automatic int nxt_y(input int y, input int d);
        if (d == 0) return y - 1;
        if (d == 2) return y + 1;
        return y;
    endfunction

    function automatic bit on_grid(input int x, input int y);
        return (x >= 0) && (x <= 9) && (y >= 0) && (y <= 9);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int greedy_dir(input int x, input int y, input int gx, input int gy);
        if (gx > x) return 1;
        if (gx < x) return 3;
        if (gy > y) return 2;
        return 0;
    endfunction

    task automatic run_trial(input int sx, input int sy, input int gx, input int gy,
                             input int mode, input int rmode);
        int ex, ey, steps, plan_cnt, pdir, pdist, done_cyc, start_cyc, hs_cyc, low_left;
        int exp_st, cyc;
        bit got_done, aborted, nopath, timed_out, in_range, prev_valid, rdy, pvalid;
        in_range   = (sx <= 9) && (sy <= 9) && (gx <= 9) && (gy <= 9);
        ex = sx; ey = sy; steps = 0; plan_cnt = -1; pdir = 0; pdist = 0; pvalid = 1'b0;
        done_cyc = -100; start_cyc = 0; hs_cyc = -1;
        low_left   = (rmode == R_LOW50) ? 50 : 0;
        got_done   = 1'b0; aborted = 1'b0; nopath = 1'b0; timed_out = 1'b0;
        prev_valid = 1'b0;
        @(negedge clk);
        go = 1'b1; abort = 1'b0; bfs_done = 1'b0;
        start_x = 4'(sx); start_y = 4'(sy); goal_x = 4'(gx); goal_y = 4'(gy);
        for (cyc = 1; cyc < 3000 && !got_done; cyc++) begin
            @(negedge clk);
            go = 1'b0; bfs_done = 1'b0; abort = 1'b0;
            if (done) begin
                got_done = 1'b1;
                if (!in_range)             exp_st = 1;
                else if (aborted || timed_out) exp_st = 3;
                else if (nopath)           exp_st = 1;
                else if (ex == gx && ey == gy) exp_st = 0;
                else                       exp_st = 2;
                check_eq("status", int'(status), exp_st);
                check_eq("step_count", int'(step_count), steps);
                check_eq("final_x", int'(curr_x), ex);
                check_eq("final_y", int'(curr_y), ey);
                check_eq("busy_at_done", int'(busy), 0);
                if (in_range && sx == gx && sy == gy) check_eq("arrive_latency", cyc, 3);
                if (timed_out) check_eq("timeout_latency", cyc - start_cyc, int'(TMO) + 1);
            end else begin
                check_eq("busy_during_run", int'(busy), 1);
            end

            if (bfs_start) begin
                check_eq("launch_allowed",
                         int'(in_range && !(ex == gx && ey == gy) && steps < int'(MAXS)), 1);
                check_eq("launch_x", int'(curr_x), ex);
                check_eq("launch_y", int'(curr_y), ey);
                check_eq("planner_goal_x", int'(bfs_goal_x), gx);
                check_eq("planner_goal_y", int'(bfs_goal_y), gy);
                if (hs_cyc >= 0) check_eq("handshake_to_start", cyc - hs_cyc, 2);
                start_cyc = cyc;
                if (mode == M_TIMEOUT) timed_out = 1'b1;
                else plan_cnt = int'($urandom_range(1, 4));
                if (mode == M_ABORT_WAIT) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
                if (mode == M_GREEDY && steps == 0) begin
                    // go while busy must be ignored
                    go = 1'b1;
                    start_x = 4'($urandom_range(0, 15));
                    goal_x  = 4'($urandom_range(0, 15));
                end
            end

            if (plan_cnt > 0) begin
                plan_cnt--;
                if (plan_cnt == 0) begin
                    pdist  = iabs(gx - ex) + iabs(gy - ey);
                    pvalid = 1'b1;
                    pdir   = greedy_dir(ex, ey, gx, gy);
                    case (mode)
                        M_WANDER: begin
                            pdist = 50;
                            do pdir = int'($urandom_range(0, 3));
                            while (!on_grid(nxt_x(ex, pdir), nxt_y(ey, pdir)));
                        end
                        M_NOPATH:  begin pdist = 127; pdir = int'($urandom_range(0, 3)); end
                        M_NOVALID: pvalid = 1'b0;
                        M_OFFGRID: begin
                            if (ex == 0)      pdir = 3;
                            else if (ex == 9) pdir = 1;
                            else if (ey == 0) pdir = 0;
                            else if (ey == 9) pdir = 2;
                        end
                        default: ;
                    endcase
                    nopath = (pdist == 127) || !pvalid ||
                             !on_grid(nxt_x(ex, pdir), nxt_y(ey, pdir));
                    bfs_dist_curr  = 7'(pdist);
                    bfs_next_dir   = 2'(pdir);
                    bfs_next_valid = pvalid;
                    bfs_done       = 1'b1;
                    done_cyc       = cyc;
                    plan_cnt       = -1;
                end
            end

            if (move_valid) begin
                if (!prev_valid) begin
                    check_eq("done_to_move_valid", cyc - done_cyc, 2);
                    check_eq("move_after_nopath", int'(nopath), 0);
                end
                check_eq("move_dir_stable", int'(move_dir), pdir);
                if (rmode == R_HIGH) rdy = 1'b1;
                else if (rmode == R_RAND) rdy = ($urandom_range(0, 2) == 0);
                else if (low_left > 0) begin rdy = 1'b0; low_left--; end
                else rdy = 1'b1;
                if (mode == M_ABORT) begin
                    abort   = 1'b1;
                    rdy     = 1'b1;
                    aborted = 1'b1;
                end else if (rdy) begin
                    ex = nxt_x(ex, pdir);
                    ey = nxt_y(ey, pdir);
                    steps++;
                    hs_cyc = cyc;
                end
                move_ready = rdy;
            end else begin
                move_ready = (rmode == R_HIGH) || (rmode == R_RAND && $urandom_range(0, 1) == 0);
            end
            prev_valid = move_valid;
        end
        if (!got_done) check_eq("run_finished", 0, 1);
        // A stray planner done in IDLE must not wake the navigator.
        @(negedge clk);
        bfs_done = 1'b1; move_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            bfs_done = 1'b0;
            check_eq("idle_busy", int'(busy), 0);
            check_eq("idle_done", int'(done), 0);
            check_eq("idle_start", int'(bfs_start), 0);
        end
    endtask

    initial begin
        int sx, sy, gx, gy;
        rstn = 1'b0; go = 1'b0; abort = 1'b0;
        start_x = '0; start_y = '0; goal_x = '0; goal_y = '0;
        bfs_done = 1'b0; bfs_dist_curr = '0; bfs_next_dir = '0; bfs_next_valid = 1'b0;
        move_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_curr_x", int'(curr_x), 0);
        check_eq("rst_curr_y", int'(curr_y), 0);
        check_eq("rst_goal_x", int'(bfs_goal_x), 0);
        check_eq("rst_goal_y", int'(bfs_goal_y), 0);
        check_eq("rst_status", int'(status), 0);
        check_eq("rst_steps", int'(step_count), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_move_valid", int'(move_valid), 0);
        check_eq("rst_bfs_start", int'(bfs_start), 0);
        rstn = 1'b1;

        run_trial(0, 0, 0, 0, M_GREEDY, R_HIGH);
        run_trial(0, 0, 2, 0, M_GREEDY, R_HIGH);
        run_trial(3, 4, 7, 7, M_NOPATH, R_HIGH);
        run_trial(5, 5, 8, 1, M_GREEDY, R_LOW50);
        run_trial(2, 2, 6, 6, M_TIMEOUT, R_HIGH);
        run_trial(0, 0, 9, 9, M_GREEDY, R_RAND);
        run_trial(4, 4, 9, 9, M_WANDER, R_HIGH);
        run_trial(1, 1, 5, 5, M_ABORT, R_HIGH);
        run_trial(6, 2, 1, 8, M_ABORT_WAIT, R_RAND);
        run_trial(0, 3, 5, 5, M_OFFGRID, R_HIGH);
        run_trial(4, 6, 2, 2, M_NOVALID, R_HIGH);
        run_trial(12, 0, 3, 3, M_GREEDY, R_HIGH);
        run_trial(3, 3, 3, 10, M_GREEDY, R_HIGH);

        for (int t = 0; t < 24; t++) begin
            sx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            sy = int'($urandom_range(0, 9));
            gx = int'($urandom_range(0, 9));
            gy = int'($urandom_range(0, 9));
            run_trial(sx, sy, gx, gy, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a run returns everything to reset values.
        @(negedge clk);
        go = 1'b1; start_x = 4'd1; start_y = 4'd1; goal_x = 4'd8; goal_y = 4'd8;
        @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("midrun_busy", int'(busy), 1);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("midrun_rst_busy", int'(busy), 0);
        check_eq("midrun_rst_curr_x", int'(curr_x), 0);
        check_eq("midrun_rst_goal_x", int'(bfs_goal_x), 0);
        check_eq("midrun_rst_status", int'(status), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
